// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and helpers for the sequential multiply/divide unit.
//   op_e     : decoded operation (unsigned mul, signed mul, unsigned divide)
//   state_e  : control FSM states
//   counterWidth() : width of the per-bit iteration counter for an N-bit unit
//   decodeOp()     : maps the raw 2-bit op field onto op_e (11 behaves as 10)
// -----------------------------------------------------------------------------
package muldiv_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      OP_MULU = 2'b00,
      OP_MULS = 2'b01,
      OP_DIVU = 2'b10
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // The counter only has to hold N-1, so $clog2(N) bits are enough.
   function automatic int counterWidth(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // The reserved code 11 is treated exactly like an unsigned divide.
   function automatic op_e decodeOp(input logic [1:0] code);
      case (code)
         2'b00:   return OP_MULU;
         2'b01:   return OP_MULS;
         default: return OP_DIVU;
      endcase
   endfunction

endpackage

// File: rtl/muldiv_seq_cond_negate.sv
// -----------------------------------------------------------------------------
// cond_negate
// Two's-complement negate of a W-bit value when en is high, pass-through
// otherwise. Used for operand magnitudes and for the signed product.
//   en : 1 = output -x, 0 = output x
//   x  : W-bit input
//   y  : W-bit output
// -----------------------------------------------------------------------------
module cond_negate #(
   parameter int W = 8
) (
   input  logic         en,
   input  logic [W-1:0] x,
   output logic [W-1:0] y
);

   // Negating the most negative value wraps to itself, which read as an
   // unsigned magnitude is exactly 2^(W-1), so no special case is required.
   always_comb begin
      y = en ? (~x + W'(1)) : x;
   end

endmodule

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
// Sequential N-bit multiply/divide unit, one result bit per clock.
// Shift-add multiply (unsigned and signed via magnitudes) and restoring divide.
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   start       : request, accepted only while busy=0
//   op          : 00 unsigned mul, 01 signed mul, 10/11 unsigned divide
//   a, b        : operands, captured when start is accepted
//   busy        : high while iterating
//   done        : one-cycle pulse when result becomes valid
//   result      : mul -> 2N-bit product, div -> {remainder, quotient}
//   div_by_zero : set with done for a divide by zero, held with result
// Build option: define MULDIV_EARLY_EXIT_EN to let multiplies finish as soon
// as the remaining multiplier bits are all zero (minimum one iteration).
// -----------------------------------------------------------------------------
import muldiv_pkg::*;

module muldiv_seq #(
   parameter int N = DEFAULT_WIDTH
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [1:0]     op,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] result,
   output logic           div_by_zero
);

   localparam int CW = counterWidth(N);

   state_e         state;
   state_e         stateNext;
   op_e            startOp;
   op_e            opReg;
   logic           accept;
   logic           lastIter;
   logic           earlyExit;
   logic [CW-1:0]  count;
   logic           signReg;

   logic           negA;
   logic           negB;
   logic [N-1:0]   magA;
   logic [N-1:0]   magB;

   logic [2*N-1:0] acc;
   logic [2*N-1:0] mcand;
   logic [N-1:0]   mplier;
   logic [2*N-1:0] nextAcc;
   logic [2*N-1:0] product;

   logic [N-1:0]   remReg;
   logic [N-1:0]   quoReg;
   logic [N-1:0]   divisor;
   logic [N:0]     divShift;
   logic [N:0]     divDiff;
   logic           divFits;
   logic [N-1:0]   nextRem;
   logic [N-1:0]   nextQuo;

   logic [2*N-1:0] finalResult;

   // Operand magnitudes are only taken for a signed multiply; every other
   // op sees the raw operands through the pass-through path.
   assign startOp = decodeOp(op);
   assign negA    = (startOp == OP_MULS) && a[N-1];
   assign negB    = (startOp == OP_MULS) && b[N-1];

   cond_negate #(.W(N)) uNegA (
      .en (negA),
      .x  (a),
      .y  (magA)
   );

   cond_negate #(.W(N)) uNegB (
      .en (negB),
      .x  (b),
      .y  (magB)
   );

   // One shift-add step: the accumulator picks up the shifted multiplicand
   // whenever the multiplier bit currently at the bottom is set.
   always_comb begin
      nextAcc = acc;
      if (mplier[0]) begin
         nextAcc = acc + mcand;
      end
   end

   // The final accumulator value is negated here when the operand signs
   // differed, so the stored product is already in two's complement.
   cond_negate #(.W(2*N)) uNegP (
      .en (signReg),
      .x  (nextAcc),
      .y  (product)
   );

   // One restoring-divide step: bring the next dividend bit into the partial
   // remainder and subtract the divisor if it fits. With a zero divisor it
   // always "fits", leaving quotient all ones and remainder equal to a.
   always_comb begin
      divShift = {remReg, quoReg[N-1]};
      divDiff  = divShift - {1'b0, divisor};
      divFits  = (divShift >= {1'b0, divisor});
      nextRem  = divFits ? divDiff[N-1:0] : divShift[N-1:0];
      nextQuo  = {quoReg[N-2:0], divFits};
   end

   // The value committed to result on the last iteration.
   always_comb begin
      finalResult = product;
      if (opReg == OP_DIVU) begin
         finalResult = {nextRem, nextQuo};
      end
   end

   // Early exit looks at the multiplier bits that would remain after this
   // step; in the default build multiplies always run all N iterations.
   always_comb begin
`ifdef MULDIV_EARLY_EXIT_EN
      earlyExit = (opReg != OP_DIVU) && (mplier[N-1:1] == '0);
`else
      earlyExit = 1'b0;
`endif
      lastIter = (count == '0) || earlyExit;
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state and handshake outputs. A start in the DONE cycle is taken
   // directly so consecutive operations run with no idle gap.
   always_comb begin
      stateNext = state;
      accept    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               stateNext = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (lastIter) begin
               stateNext = S_DONE;
            end
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               accept    = 1'b1;
               stateNext = S_RUN;
            end else begin
               stateNext = S_IDLE;
            end
         end
         default: begin
            stateNext = S_IDLE;
         end
      endcase
   end

   // Datapath. Operands are captured on acceptance so later input changes are
   // harmless; result and div_by_zero only move on the final iteration, so
   // they hold the previous answer throughout RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opReg       <= OP_MULU;
         signReg     <= 1'b0;
         count       <= '0;
         acc         <= '0;
         mcand       <= '0;
         mplier      <= '0;
         remReg      <= '0;
         quoReg      <= '0;
         divisor     <= '0;
         result      <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         opReg       <= startOp;
         signReg     <= (startOp == OP_MULS) && (a[N-1] ^ b[N-1]);
         count       <= CW'(N-1);
         acc         <= '0;
         mcand       <= {{N{1'b0}}, magA};
         mplier      <= magB;
         remReg      <= '0;
         quoReg      <= a;
         divisor     <= b;
         div_by_zero <= 1'b0;
      end else if (state == S_RUN) begin
         count <= count - 1'b1;
         if (opReg == OP_DIVU) begin
            remReg <= nextRem;
            quoReg <= nextQuo;
         end else begin
            acc    <= nextAcc;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
         end
         if (lastIter) begin
            result      <= finalResult;
            div_by_zero <= (opReg == OP_DIVU) && (divisor == '0);
         end
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
// Self-checking bench for muldiv_seq (N=8). A cycle-level arithmetic model
// predicts busy/done/result/div_by_zero and is compared every cycle; directed
// vectors also check hand-computed results and latencies.
// Honours MULDIV_EARLY_EXIT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;

   localparam int N = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic           start = 1'b0;
   logic [1:0]     op = 2'b00;
   logic [N-1:0]   a = '0;
   logic [N-1:0]   b = '0;
   logic           busy;
   logic           done;
   logic [2*N-1:0] result;
   logic           div_by_zero;

   int assertCount  = 0;
   int failureCount = 0;
   int latCount     = 0;

   // Model state: what the outputs must be after the most recent edge.
   logic           mBusy   = 1'b0;
   logic           mDone   = 1'b0;
   logic [2*N-1:0] mResult = '0;
   logic           mDbz    = 1'b0;
   logic [2*N-1:0] pendResult = '0;
   logic           pendDbz    = 1'b0;
   int             remaining  = 0;

   muldiv_seq #(.N(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .div_by_zero (div_by_zero)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Single comparison point used by every check in the bench.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failureCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name,
                  actual, expected, $time);
      end
   endtask

   // Arithmetic answer for one operation, straight from the operation's meaning.
   function automatic logic [2*N-1:0] expectedResult(input logic [1:0] o,
                                                     input logic [N-1:0] x,
                                                     input logic [N-1:0] y);
      int          sx;
      int          sy;
      logic [31:0] p;
      case (o)
         2'b00: begin
            p = 32'(x) * 32'(y);
         end
         2'b01: begin
            sx = int'($signed(x));
            sy = int'($signed(y));
            p  = 32'(sx * sy);
         end
         default: begin
            if (y == '0) p = {16'h0, x, 8'hFF};
            else         p = {16'h0, 8'(x % y), 8'(x / y)};
         end
      endcase
      return p[2*N-1:0];
   endfunction

   // Number of cycles spent computing: N, or for early-exit multiplies the
   // bit length of the multiplier magnitude (at least one).
   function automatic int expectedRunCycles(input logic [1:0] o,
                                            input logic [N-1:0] y);
      logic [N-1:0] mag;
      int           bits;
      int           cycles;
      cycles = N;
`ifdef MULDIV_EARLY_EXIT_EN
      if (o == 2'b00 || o == 2'b01) begin
         mag  = (o == 2'b01 && y[N-1]) ? N'(-y) : y;
         bits = 0;
         for (int i = 0; i < N; i++) begin
            if (mag[i]) bits = i + 1;
         end
         cycles = (bits < 1) ? 1 : bits;
      end
`else
      mag    = y;
      bits   = int'(mag[0]);
      cycles = N + 0 * bits;
`endif
      return cycles;
   endfunction

   // Behavioural model advanced on every rising edge, cleared by reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mBusy     = 1'b0;
         mDone     = 1'b0;
         mResult   = '0;
         mDbz      = 1'b0;
         remaining = 0;
      end else begin
         mDone = 1'b0;
         if (mBusy) begin
            remaining--;
            if (remaining == 0) begin
               mBusy   = 1'b0;
               mDone   = 1'b1;
               mResult = pendResult;
               mDbz    = pendDbz;
            end
         end else if (start) begin
            remaining  = expectedRunCycles(op, b);
            mBusy      = 1'b1;
            pendResult = expectedResult(op, a, b);
            pendDbz    = op[1] && (b == '0);
            mDbz       = 1'b0;
         end
      end
   end

   // Every falling edge the DUT outputs must equal the model.
   always @(negedge clk) begin
      checkOutput("busy", 32'(busy), 32'(mBusy));
      checkOutput("done", 32'(done), 32'(mDone));
      checkOutput("result", 32'(result), 32'(mResult));
      checkOutput("div_by_zero", 32'(div_by_zero), 32'(mDbz));
   end

   // Presents one request, waits for the accepting edge, then scrambles the
   // operand inputs so the design must rely on its captured copies.
   task automatic applyStimulus(input logic [1:0] o, input logic [N-1:0] x,
                                input logic [N-1:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      latCount = 1;
      #1;
      start = 1'b0;
      a     = N'($urandom);
      b     = N'($urandom);
      op    = 2'($urandom);
   endtask

   task automatic stepCycle();
      @(posedge clk);
      latCount++;
      #1;
   endtask

   // Bounded wait for the done pulse; leaves time inside the DONE cycle.
   task automatic waitDone();
      while (!done && latCount < 40) begin
         stepCycle();
      end
      if (!done) begin
         checkOutput("done_timeout", 32'(done), 32'd1);
      end
   endtask

   initial begin
      int sawDone;

      $display("[TB] muldiv_seq directed test, N=%0d", N);
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_result", 32'(result), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      #1;

      // 1. unsigned multiply
      applyStimulus(2'b00, 8'd200, 8'd150);
      waitDone();
      checkOutput("mulu_latency", 32'(latCount), 32'd9);
      checkOutput("mulu_result", 32'(result), 32'h7530);
      checkOutput("mulu_dbz", 32'(div_by_zero), 32'd0);

      // 2. signed multiply, then a back-to-back request in the DONE cycle
      @(negedge clk);
      #1;
      applyStimulus(2'b01, 8'h80, 8'h80);
      waitDone();
      checkOutput("muls_minmin", 32'(result), 32'h4000);
      applyStimulus(2'b01, 8'hFD, 8'h05);
      checkOutput("b2b_busy", 32'(busy), 32'd1);
      waitDone();
      checkOutput("muls_neg", 32'(result), 32'hFFF1);

      // 3. divide, and the reserved code behaving as divide
      applyStimulus(2'b10, 8'd200, 8'd7);
      waitDone();
      checkOutput("divu_latency", 32'(latCount), 32'd9);
      checkOutput("divu_result", 32'(result), 32'h041C);
      applyStimulus(2'b11, 8'd200, 8'd7);
      waitDone();
      checkOutput("op11_result", 32'(result), 32'h041C);

      // 4. divide by zero, flag cleared by the next accepted start
      applyStimulus(2'b10, 8'h55, 8'h00);
      waitDone();
      checkOutput("dbz_result", 32'(result), 32'h55FF);
      checkOutput("dbz_flag", 32'(div_by_zero), 32'd1);
      @(negedge clk);
      #1;
      checkOutput("dbz_held", 32'(div_by_zero), 32'd1);
      applyStimulus(2'b00, 8'd3, 8'd4);
      checkOutput("dbz_cleared", 32'(div_by_zero), 32'd0);
      waitDone();
      checkOutput("mul_small", 32'(result), 32'h000C);

      // 5a. start while busy is ignored
      @(negedge clk);
      #1;
      applyStimulus(2'b00, 8'd200, 8'd150);
      stepCycle();
      stepCycle();
      start = 1'b1;
      op    = 2'b10;
      a     = 8'd9;
      b     = 8'd2;
      stepCycle();
      start = 1'b0;
      waitDone();
      checkOutput("ignored_latency", 32'(latCount), 32'd9);
      checkOutput("ignored_result", 32'(result), 32'h7530);

      // 5b. reset in the middle of a run
      @(negedge clk);
      #1;
      applyStimulus(2'b01, 8'h12, 8'h34);
      stepCycle();
      stepCycle();
      stepCycle();
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_result", 32'(result), 32'd0);
      @(negedge clk);
      #1;
      rst_n   = 1'b1;
      sawDone = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done) sawDone++;
      end
      checkOutput("abort_no_done", 32'(sawDone), 32'd0);

`ifdef MULDIV_EARLY_EXIT_EN
      // 6. early exit latencies
      @(negedge clk);
      #1;
      applyStimulus(2'b00, 8'hFF, 8'h03);
      waitDone();
      checkOutput("early_latency", 32'(latCount), 32'd3);
      checkOutput("early_result", 32'(result), 32'h02FD);
      applyStimulus(2'b00, 8'hFF, 8'h00);
      waitDone();
      checkOutput("early_zero_latency", 32'(latCount), 32'd2);
      checkOutput("early_zero_result", 32'(result), 32'h0000);
      applyStimulus(2'b10, 8'd200, 8'd7);
      waitDone();
      checkOutput("early_div_latency", 32'(latCount), 32'd9);
      checkOutput("early_div_result", 32'(result), 32'h041C);
`endif

      repeat (2) @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failureCount);
      $finish;
   end

endmodule
